// File: rtl/pkt_pkg.sv
// Shared definitions for the serial packet link (pkt_snd / pkt_rcv).
// Holds the common packet width, the bit-count width helper and the receiver FSM states.
package pkt_pkg;

    localparam int PKT_W_DEF = 16;

    // Count has to reach PKT_W+1 so long frames stay distinguishable from full ones.
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

    localparam int CNT_W_DEF = cnt_width(PKT_W_DEF);

    typedef enum logic {IDLE, SHIFT} state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for one asynchronous input, with level and one-cycle edge outputs.
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sq;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq   <= {STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            sq   <= {sq[STAGES-2:0], d};
            prev <= sq[STAGES-1];
        end
    end

    assign level = sq[STAGES-1];
    assign rise  = sq[STAGES-1] & ~prev;
    assign fall  = ~sq[STAGES-1] & prev;

endmodule

// File: rtl/pkt_rcv.sv
// Serial packet receiver: oversamples the sclk/load/sdi stream from pkt_snd and rebuilds
// PKT_W-bit words, flagging framing errors and overruns.
module pkt_rcv
    import pkt_pkg::*;
#(
    parameter int PKT_W       = PKT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             load,
    input  logic             sdi,
    output logic [PKT_W-1:0] pkt,
    output logic             pvld,
    input  logic             pack,
    output logic             ovr,
    output logic             ferr
);

    localparam int CNT_W = cnt_width(PKT_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PKT_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(PKT_W + 1);

    logic sclk_rise, sclk_level_unused, sclk_fall_unused;
    logic load_rise, load_fall, load_level_unused;
    logic sdi_sync, sdi_rise_unused, sdi_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    // load idles high, so its synchroniser resets high to avoid a false frame start.
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_load (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (load),
        .level (load_level_unused),
        .rise  (load_rise),
        .fall  (load_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sdi),
        .level (sdi_sync),
        .rise  (sdi_rise_unused),
        .fall  (sdi_fall_unused)
    );

    state_t           state;
    logic [PKT_W-1:0] sr;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            pkt   <= '0;
            pvld  <= 1'b0;
            ovr   <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            ferr <= 1'b0;
            if (pack && pvld) begin
                pvld <= 1'b0;
                ovr  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (load_fall) begin
                        sr    <= '0;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // load_rise takes priority: a coincident sclk_rise bit is dropped.
                    if (load_rise) begin
                        state <= IDLE;
                        if (cnt == CNT_FULL) begin
                            if (!pvld || pack) begin
                                pkt  <= sr;
                                pvld <= 1'b1;
                            end else begin
                                ovr <= 1'b1;
                            end
                        end else begin
                            ferr <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        sr <= {sr[PKT_W-2:0], sdi_sync};
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
